// File: rtl/issue_pkg.sv
// Shared constants and state type for the issue controller and its scoreboard.
package issue_pkg;

    localparam int unsigned NUM_FU     = 5;
    localparam int unsigned FU_ALU0    = 0;
    localparam int unsigned FU_ALU1    = 1;
    localparam int unsigned FU_COMPLEX = 2;
    localparam int unsigned FU_MEM     = 3;
    localparam int unsigned FU_BRANCH  = 4;

    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned REG_AW     = 4;

    typedef enum logic {RUN, BRANCH_WAIT} issue_state_t;

endpackage

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// r0 is never marked busy; a set and a clear to the same register resolve to set.
module register_scoreboard
    import issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [REG_AW-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [REG_AW-1:0] clr_addr_i,
    input  logic [REG_AW-1:0] rd_a_addr_i,
    input  logic [REG_AW-1:0] rd_b_addr_i,
    output logic              busy_a_o,
    output logic              busy_b_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Reads see registered state only: no writeback bypass.
    assign busy_a_o = busy_q[rd_a_addr_i];
    assign busy_b_o = busy_q[rd_b_addr_i];

endmodule

// File: rtl/issue_controller.sv
// Single-entry issue stage: hazard/tag gating, one-hot dispatch to five units, branch wait.
// Optional ISSUE_PERF_COUNTERS_EN adds saturating StallCycles/BranchWaitCycles outputs.
module issue_controller
    import issue_pkg::*;
#(
    parameter int unsigned TAGBITWIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   DecodeValid,
    output logic                   DecodeReady,
    input  logic [4:0]             FunctionalUnitEnable,
    input  logic                   TagRequest,
    input  logic                   RegAReadEn,
    input  logic                   RegAWriteEn,
    input  logic                   RegBReadEn,
    input  logic                   BranchStall,
    input  logic                   JumpEn,
    input  logic [3:0]             RegAAddr,
    input  logic [3:0]             RegBAddr,
    output logic [4:0]             IssueValid,
    input  logic [4:0]             IssueReady,
    output logic [TAGBITWIDTH-1:0] IssueTag,
    input  logic                   WritebackValid,
    input  logic [3:0]             WritebackAddr,
    input  logic                   TagRelease,
    input  logic                   BranchResolved
`ifdef ISSUE_PERF_COUNTERS_EN
    ,
    output logic [31:0]            StallCycles,
    output logic [31:0]            BranchWaitCycles
`endif
);

    localparam int unsigned CNT_W    = TAGBITWIDTH + 1;
    localparam int unsigned NUM_TAGS = 1 << TAGBITWIDTH;

    issue_state_t           state_q;
    logic [NUM_FU-1:0]      issue_valid_q, issue_valid_d;
    logic [TAGBITWIDTH-1:0] issue_tag_q, issue_tag_d;
    logic [TAGBITWIDTH-1:0] tag_cnt_q, tag_cnt_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;

    logic busy_a, busy_b;
    logic draining, slot_free, hazard, tag_ok, accept, alloc;

    // Jumps and immediates need no unit; JumpEn carries no extra issue behaviour.
    logic unused_jump_en;
    assign unused_jump_en = JumpEn;

    register_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (accept && RegAWriteEn),
        .set_addr_i  (RegAAddr),
        .clr_en_i    (WritebackValid),
        .clr_addr_i  (WritebackAddr),
        .rd_a_addr_i (RegAAddr),
        .rd_b_addr_i (RegBAddr),
        .busy_a_o    (busy_a),
        .busy_b_o    (busy_b)
    );

    assign draining  = |(issue_valid_q & IssueReady);
    assign slot_free = (issue_valid_q == '0) || draining;
    assign hazard    = ((RegAReadEn || RegAWriteEn) && busy_a) || (RegBReadEn && busy_b);
    assign tag_ok    = !TagRequest || (outstanding_q < CNT_W'(NUM_TAGS));

    assign DecodeReady = !rst && (state_q == RUN) && slot_free && !hazard && tag_ok;
    assign accept      = DecodeValid && DecodeReady;
    assign alloc       = accept && TagRequest;

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_tag_d   = issue_tag_q;
        tag_cnt_d     = tag_cnt_q;
        outstanding_d = outstanding_q;

        // Unit-less instructions are accepted but leave the register empty.
        if (accept) begin
            issue_valid_d = FunctionalUnitEnable;
            issue_tag_d   = (alloc && (FunctionalUnitEnable != '0)) ? tag_cnt_q : '0;
        end else if (draining) begin
            issue_valid_d = '0;
            issue_tag_d   = '0;
        end

        if (alloc) begin
            tag_cnt_d = tag_cnt_q + TAGBITWIDTH'(1);
        end

        if (alloc && !TagRelease) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!alloc && TagRelease && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            issue_valid_q <= '0;
            issue_tag_q   <= '0;
            tag_cnt_q     <= '0;
            outstanding_q <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_tag_q   <= issue_tag_d;
            tag_cnt_q     <= tag_cnt_d;
            outstanding_q <= outstanding_d;
            case (state_q)
                RUN:         if (accept && BranchStall) state_q <= BRANCH_WAIT;
                BRANCH_WAIT: if (BranchResolved)        state_q <= RUN;
                default:                                state_q <= RUN;
            endcase
        end
    end

    assign IssueValid = issue_valid_q;
    assign IssueTag   = issue_tag_q;

`ifdef ISSUE_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] branch_wait_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q       <= '0;
            branch_wait_cycles_q <= '0;
        end else begin
            if (DecodeValid && !DecodeReady && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if ((state_q == BRANCH_WAIT) && (branch_wait_cycles_q != 32'hFFFF_FFFF)) begin
                branch_wait_cycles_q <= branch_wait_cycles_q + 32'd1;
            end
        end
    end

    assign StallCycles      = stall_cycles_q;
    assign BranchWaitCycles = branch_wait_cycles_q;
`endif

endmodule

// File: tb/tb_issue_controller.sv
// Bench for issue_controller (TAGBITWIDTH=2): directed vector table, branch/reset sequences,
// then randomized traffic against a behavioural model.
module tb_issue_controller;
    import issue_pkg::*;

    localparam int unsigned TW    = 2;
    localparam int          NTAGS = 4;

    localparam logic [4:0] A0  = 5'b00001;
    localparam logic [4:0] A1  = 5'b00010;
    localparam logic [4:0] CX  = 5'b00100;
    localparam logic [4:0] MEM = 5'b01000;
    localparam logic [4:0] BR  = 5'b10000;
    localparam logic [4:0] ALL = 5'b11111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          DecodeValid = 1'b0;
    logic          DecodeReady;
    logic [4:0]    FunctionalUnitEnable = '0;
    logic          TagRequest = 1'b0, RegAReadEn = 1'b0, RegAWriteEn = 1'b0, RegBReadEn = 1'b0;
    logic          BranchStall = 1'b0, JumpEn = 1'b0;
    logic [3:0]    RegAAddr = '0, RegBAddr = '0;
    logic [4:0]    IssueValid;
    logic [4:0]    IssueReady = '0;
    logic [TW-1:0] IssueTag;
    logic          WritebackValid = 1'b0;
    logic [3:0]    WritebackAddr = '0;
    logic          TagRelease = 1'b0, BranchResolved = 1'b0;
`ifdef ISSUE_PERF_COUNTERS_EN
    logic [31:0]   StallCycles, BranchWaitCycles;
`endif

    always #5 clk = ~clk;

    issue_controller #(.TAGBITWIDTH(TW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .DecodeValid          (DecodeValid),
        .DecodeReady          (DecodeReady),
        .FunctionalUnitEnable (FunctionalUnitEnable),
        .TagRequest           (TagRequest),
        .RegAReadEn           (RegAReadEn),
        .RegAWriteEn          (RegAWriteEn),
        .RegBReadEn           (RegBReadEn),
        .BranchStall          (BranchStall),
        .JumpEn               (JumpEn),
        .RegAAddr             (RegAAddr),
        .RegBAddr             (RegBAddr),
        .IssueValid           (IssueValid),
        .IssueReady           (IssueReady),
        .IssueTag             (IssueTag),
        .WritebackValid       (WritebackValid),
        .WritebackAddr        (WritebackAddr),
        .TagRelease           (TagRelease),
        .BranchResolved       (BranchResolved)
`ifdef ISSUE_PERF_COUNTERS_EN
        ,
        .StallCycles          (StallCycles),
        .BranchWaitCycles     (BranchWaitCycles)
`endif
    );

    typedef struct {
        logic       rst, dv;
        logic [4:0] fue;
        logic       treq, ard, awr, brd, bst;
        logic [3:0] ra, rb;
        logic [4:0] ird;
        logic       wbv;
        logic [3:0] wba;
        logic       trel, bres;
        logic       exp_rdy;
        logic [4:0] exp_iv;
        int         exp_tag;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic r, input logic dv, input logic [4:0] fue,
                                 input logic treq, input logic ard, input logic awr,
                                 input logic brd, input logic bst, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic [4:0] ird, input logic wbv,
                                 input logic [3:0] wba, input logic trel, input logic bres,
                                 input logic erdy, input logic [4:0] eiv, input int etag);
        vec_t v;
        v.rst = r; v.dv = dv; v.fue = fue; v.treq = treq; v.ard = ard; v.awr = awr;
        v.brd = brd; v.bst = bst; v.ra = ra; v.rb = rb; v.ird = ird; v.wbv = wbv;
        v.wba = wba; v.trel = trel; v.bres = bres;
        v.exp_rdy = erdy; v.exp_iv = eiv; v.exp_tag = etag;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; DecodeValid = v.dv; FunctionalUnitEnable = v.fue; TagRequest = v.treq;
        RegAReadEn = v.ard; RegAWriteEn = v.awr; RegBReadEn = v.brd; BranchStall = v.bst;
        JumpEn = 1'b0; RegAAddr = v.ra; RegBAddr = v.rb; IssueReady = v.ird;
        WritebackValid = v.wbv; WritebackAddr = v.wba; TagRelease = v.trel;
        BranchResolved = v.bres;
    endtask

    // Inputs change on the falling edge; ready is checked mid-low-phase, outputs after the rising edge.
    task automatic apply_row(input vec_t v, input string lbl);
        @(negedge clk);
        drive(v);
        #1;
        chk({lbl, " DecodeReady"}, int'(DecodeReady), int'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk({lbl, " IssueValid"}, int'(IssueValid), int'(v.exp_iv));
        chk({lbl, " IssueTag"}, int'(IssueTag), v.exp_tag);
    endtask

    // Behavioural model state
    bit mbusy[16];
    int mout, mnext, mheld, mhtag;
    bit mbw;

    task automatic model_reset();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        mout = 0; mnext = 0; mheld = -1; mhtag = 0; mbw = 1'b0;
    endtask

    function automatic bit model_ready();
        bit slot, haz;
        if (rst) return 1'b0;
        slot = (mheld < 0) || IssueReady[mheld];
        haz  = ((RegAReadEn || RegAWriteEn) && mbusy[RegAAddr]) || (RegBReadEn && mbusy[RegBAddr]);
        return !mbw && slot && !haz && (!TagRequest || (mout < NTAGS));
    endfunction

    task automatic model_step(input bit rdy);
        bit acc, drained;
        int k;
        if (rst) begin
            model_reset();
            return;
        end
        acc     = DecodeValid && rdy;
        drained = (mheld >= 0) && IssueReady[mheld];
        if (acc) begin
            mheld = -1;
            for (int i = 0; i < 5; i++) if (FunctionalUnitEnable[i]) mheld = i;
            mhtag = (mheld >= 0 && TagRequest) ? mnext : 0;
        end else if (drained) begin
            mheld = -1;
            mhtag = 0;
        end
        if (WritebackValid) mbusy[WritebackAddr] = 1'b0;
        if (acc && RegAWriteEn && RegAAddr != 0) mbusy[RegAAddr] = 1'b1;
        k = mout;
        if (acc && TagRequest) begin
            mnext = (mnext + 1) % NTAGS;
            k++;
        end
        if (TagRelease && k > 0) k--;
        mout = k;
        if (!mbw && acc && BranchStall) mbw = 1'b1;
        else if (mbw && BranchResolved) mbw = 1'b0;
    endtask

    initial begin
        vec_t v;
        bit   r;
        int   k;

        // Reset, then four tagged Memory issues, exhaustion, release and wrap to tag 0
        tbl.push_back(mkv(1,0,0,    0,0,0,0,0, 0,0, 0,   0,0, 0,0, 0,0,0));
        tbl.push_back(mkv(1,0,0,    0,0,0,0,0, 0,0, 0,   0,0, 0,0, 0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mkv(0,1,MEM,1,0,0,0,0, 0,0, ALL, 0,0, 0,0, 1,MEM,i));
        tbl.push_back(mkv(0,1,MEM,  1,0,0,0,0, 0,0, ALL, 0,0, 0,0, 0,0,0));
        tbl.push_back(mkv(0,1,MEM,  1,0,0,0,0, 0,0, ALL, 0,0, 1,0, 0,0,0));
        tbl.push_back(mkv(0,1,MEM,  1,0,0,0,0, 0,0, ALL, 0,0, 0,0, 1,MEM,0));
        tbl.push_back(mkv(1,0,0,    0,0,0,0,0, 0,0, 0,   0,0, 0,0, 0,0,0));
        // RAW on r3: no bypass, reader issues one cycle after writeback
        tbl.push_back(mkv(0,1,A0,   1,0,1,0,0, 3,0, ALL, 0,0, 0,0, 1,A0,0));
        tbl.push_back(mkv(0,1,A0,   0,1,0,0,0, 3,0, ALL, 0,0, 0,0, 0,0,0));
        tbl.push_back(mkv(0,1,A0,   0,1,0,0,0, 3,0, ALL, 1,3, 1,0, 0,0,0));
        tbl.push_back(mkv(0,1,A0,   0,1,0,0,0, 3,0, ALL, 0,0, 0,0, 1,A0,0));
        // r0 write then read: no stall; stray BranchResolved in RUN ignored
        tbl.push_back(mkv(0,1,A0,   0,0,1,0,0, 0,0, ALL, 0,0, 0,1, 1,A0,0));
        tbl.push_back(mkv(0,1,A0,   0,1,0,0,0, 0,0, ALL, 0,0, 0,0, 1,A0,0));
        // Complex unit held while only other units are ready, then drain + accept same cycle
        tbl.push_back(mkv(0,1,CX,   0,0,0,0,0, 0,0, ALL, 0,0, 0,0, 1,CX,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mkv(0,1,A1,0,0,0,0,0, 0,0, 5'b11011, 0,0, 0,0, 0,CX,0));
        tbl.push_back(mkv(0,1,A1,   1,0,1,0,0, 7,0, 5'b00100, 0,0, 0,0, 1,A1,1));
        // WAW on r7, RAW through port B, then clear
        tbl.push_back(mkv(0,1,A0,   0,0,1,0,0, 7,0, ALL, 0,0, 0,0, 0,0,0));
        tbl.push_back(mkv(0,1,A0,   0,0,0,1,0, 2,7, ALL, 0,0, 0,0, 0,0,0));
        tbl.push_back(mkv(0,1,A0,   0,0,0,1,0, 2,7, ALL, 1,7, 0,0, 0,0,0));
        tbl.push_back(mkv(0,1,A0,   0,0,0,1,0, 2,7, ALL, 0,0, 0,0, 1,A0,0));
        // Set and clear of r9 in the same cycle: set wins
        tbl.push_back(mkv(0,1,A0,   0,0,1,0,0, 9,0, ALL, 1,9, 0,0, 1,A0,0));
        tbl.push_back(mkv(0,1,A0,   0,1,0,0,0, 9,0, ALL, 0,0, 0,0, 0,0,0));
        tbl.push_back(mkv(0,0,0,    0,0,0,0,0, 0,0, ALL, 1,9, 0,0, 1,0,0));
        // Unit-less instruction allocates a tag but never occupies the register
        tbl.push_back(mkv(0,1,0,    1,0,0,0,0, 0,0, 0,   0,0, 0,0, 1,0,0));

        foreach (tbl[i]) apply_row(tbl[i], $sformatf("vec%0d", i));

        // Branch wait: 10 stalled cycles, resolve, accept next cycle
        apply_row(mkv(0,1,BR, 0,0,0,0,1, 0,0, ALL, 0,0, 0,0, 1,BR,0), "br_accept");
        for (int i = 0; i < 10; i++)
            apply_row(mkv(0,1,A0, 0,0,0,0,0, 0,0, ALL, 0,0, 0,0, 0,0,0), $sformatf("br_wait%0d", i));
        apply_row(mkv(0,1,A0, 0,0,0,0,0, 0,0, ALL, 0,0, 0,1, 0,0,0), "br_resolve");
        apply_row(mkv(0,1,A0, 0,0,0,0,0, 0,0, ALL, 0,0, 0,0, 1,A0,0), "br_resume");

        // Mid-operation reset with r5 busy, one tag out, in branch wait and unit holding
        apply_row(mkv(1,0,0,  0,0,0,0,0, 0,0, 0,   0,0, 0,0, 0,0,0), "rs_pre");
        apply_row(mkv(0,1,A0, 1,0,1,0,1, 5,0, 0,   0,0, 0,0, 1,A0,0), "rs_setup");
        apply_row(mkv(0,1,A0, 0,1,0,0,0, 5,0, 0,   0,0, 0,0, 0,A0,0), "rs_blocked");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rs_async IssueValid", int'(IssueValid), 0);
        chk("rs_async DecodeReady", int'(DecodeReady), 0);
        apply_row(mkv(0,1,A0, 1,1,0,0,0, 5,0, 0,   0,0, 0,0, 1,A0,0), "rs_after");

        // Randomized traffic against the model
        apply_row(mkv(1,0,0,  0,0,0,0,0, 0,0, 0,   0,0, 0,0, 0,0,0), "rnd_reset");
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 199) == 0);
            DecodeValid = ($urandom_range(0, 9) < 7);
            k = $urandom_range(0, 5);
            FunctionalUnitEnable = (k == 5) ? 5'b0 : 5'(1 << k);
            TagRequest  = 1'($urandom);
            RegAReadEn  = 1'($urandom);
            RegAWriteEn = 1'($urandom);
            RegBReadEn  = 1'($urandom);
            BranchStall = ($urandom_range(0, 9) == 0);
            JumpEn      = 1'($urandom);
            RegAAddr    = 4'($urandom_range(0, 7));
            RegBAddr    = 4'($urandom_range(0, 7));
            IssueReady  = 5'($urandom);
            WritebackValid = 1'($urandom);
            WritebackAddr  = 4'($urandom_range(0, 7));
            TagRelease     = ($urandom_range(0, 9) < 3);
            BranchResolved = ($urandom_range(0, 4) == 0);
            #1;
            r = model_ready();
            chk($sformatf("rnd%0d DecodeReady", n), int'(DecodeReady), int'(r));
            model_step(r);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d IssueValid", n), int'(IssueValid), (mheld < 0) ? 0 : (1 << mheld));
            chk($sformatf("rnd%0d IssueTag", n), int'(IssueTag), (mheld < 0) ? 0 : mhtag);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_controller.md
# issue_controller

Sequences decoded instructions from the instruction decoder into the five functional units: Simple ALU 0, Simple ALU 1, Complex ALU, Memory and Branch. It holds a single-entry issue register with a valid/ready handshake to each unit. It tracks pending register writes in a 16-entry scoreboard, allocates result tags, and stalls decode on hazards, exhausted tags or unresolved branches. It sits between the decoder and the functional units and drives the decoder-side stall.

## Interface
- TAGBITWIDTH, 3, tag width; 2^TAGBITWIDTH tags can be outstanding.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- DecodeValid  in  1  decoded instruction present.
- DecodeReady  out  1  instruction accepted this cycle when high together with DecodeValid.
- FunctionalUnitEnable  in  5  one-hot unit select: b0 ALU0, b1 ALU1, b2 Complex, b3 Memory, b4 Branch.
- TagRequest, RegAReadEn, RegAWriteEn, RegBReadEn, BranchStall, JumpEn  in  1 each  decoder control bits.
- RegAAddr, RegBAddr  in  4 each  register addresses.
- IssueValid  out  5  one-hot; copy of the latched FunctionalUnitEnable while the issue register is full.
- IssueReady  in  5  per-unit ready.
- IssueTag  out  TAGBITWIDTH  tag of the held instruction; 0 if it has no tag.
- WritebackValid  in  1  result written.
- WritebackAddr  in  4  register written.
- TagRelease  in  1  frees one tag.
- BranchResolved  in  1  branch unit finished; pulse.

## Operation
- Acceptance requires all of the following:
  - DecodeValid high.
  - State is RUN.
  - Issue register empty, or draining this cycle (IssueValid & IssueReady nonzero).
  - No hazard:
    - RAW: RegAReadEn and Busy[RegAAddr], or RegBReadEn and Busy[RegBAddr].
    - WAW: RegAWriteEn and Busy[RegAAddr].
  - TagRequest low, or OutstandingTags < 2^TAGBITWIDTH.
- Busy[0] is always 0; a write to r0 never sets the scoreboard.
- The hazard check uses registered scoreboard state only. There is no writeback bypass, so a freed register is usable one cycle after WritebackValid.
- On acceptance:
  - The issue register latches FunctionalUnitEnable and the tag.
  - Busy[RegAAddr] is set if RegAWriteEn is high and RegAAddr != 0.
  - If TagRequest is high, the tag counter is assigned (wraps modulo 2^TAGBITWIDTH) and OutstandingTags increments.
- An accepted instruction with FunctionalUnitEnable == 0 (immediates, JumpEn) never occupies the issue register.
- Scoreboard clear: WritebackValid clears Busy[WritebackAddr]. If a set and a clear hit the same register in the same cycle, the set wins.
- Tag count: OutstandingTags = +1 on allocation, -1 on TagRelease; both in the same cycle leaves it unchanged. TagRelease at a count of 0 is ignored.
- States:
  - RUN: normal acceptance. Accepting with BranchStall high goes to BRANCH_WAIT.
  - BRANCH_WAIT: DecodeReady = 0. BranchResolved goes to RUN.
  - A BranchResolved pulse arriving in RUN is ignored.
- IssueValid stays stable until the addressed unit's IssueReady is high. IssueReady on unselected units is ignored.

## Timing
- Reset values:
  - DecodeReady = 0; state RUN.
  - IssueValid = 0, IssueTag = 0.
  - Busy = 0, tag counter = 0, OutstandingTags = 0.
  - DecodeReady rises combinationally in the first cycle after rst deasserts.
- Latency: accepted in cycle N gives IssueValid in cycle N+1. Back-to-back issue is possible with one instruction per cycle when each unit is ready.
- DecodeReady is combinational from state, scoreboard, counters and IssueReady. IssueValid and IssueTag are registered.
- rst asserted mid-operation immediately drops the held instruction, all busy bits and all tags.

## Configuration
- ISSUE_PERF_COUNTERS_EN defined: adds output StallCycles (32 bits) and output BranchWaitCycles (32 bits).
  - StallCycles increments when DecodeValid is high and DecodeReady is low.
  - BranchWaitCycles increments each cycle spent in BRANCH_WAIT.
  - Both saturate, and both reset to 0.
- Undefined: the ports and the counters are absent. Issue behaviour is identical either way.

## Structure
- Package issue_pkg holds:
  - FU index constants (FU_ALU0=0 through FU_BRANCH=4).
  - typedef enum logic {RUN, BRANCH_WAIT} issue_state_t.
  - The NUM_REGS=16 constant.
- Sub-module register_scoreboard:
  - Inputs: set port (en, addr), clear port (en, addr), two read addresses.
  - Outputs: two busy bits.
  - Behaviour: implements the r0 and set-wins rules.

## Test plan
- ALU0 instruction writing r3, then an instruction reading r3 next cycle: DecodeReady is 0 until one cycle after WritebackValid with WritebackAddr=3, then the reader issues.
- Write to r0 followed by a read of r0: no stall; IssueValid=5'b00001 on both consecutive cycles.
- TAGBITWIDTH=2, five Memory instructions with no TagRelease:
  - Four accepted with IssueTag 0,1,2,3.
  - The fifth stalls.
  - One TagRelease gives acceptance with IssueTag 0.
- Branch accepted with BranchStall=1: DecodeReady stays 0 for 10 cycles of DecodeValid; a BranchResolved pulse returns to RUN and accepts next cycle.
- IssueValid=5'b00100 with IssueReady=5'b11011 for 4 cycles:
  - IssueValid is held and DecodeReady is 0.
  - When IssueReady[2]=1, the held instruction drains and the next instruction is accepted in the same cycle.
- Assert rst while Busy[5]=1, one tag is outstanding and the controller is in BRANCH_WAIT: after release, an instruction reading r5 is accepted immediately with IssueTag 0.
